// File: rtl/decode_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decode_if : fetch/execute-side handshake and data bundle for decode_stage |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface decode_if #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
);
    logic                   i_valid;
    logic                   o_ready;
    logic [31:0]            i_insn;
    logic [NREGS*XLEN-1:0]  i_gpr;
    logic                   i_flush;
    logic                   i_wb_valid;
    logic [4:0]             i_wb_dst;
    logic                   o_valid;
    logic                   i_ready;
    logic [3:0]             o_to_state;
    logic [3:0]             o_alu_op;
    logic [1:0]             o_sz;
    logic [XLEN-1:0]        o_src1;
    logic [XLEN-1:0]        o_src2;
    logic [4:0]             o_dst;
    logic                   o_illegal;
    logic                   o_halted;

    modport master (
        output i_valid, i_insn, i_gpr, i_flush, i_wb_valid, i_wb_dst, i_ready,
        input  o_ready, o_valid, o_to_state, o_alu_op, o_sz, o_src1, o_src2,
               o_dst, o_illegal, o_halted
    );

    modport slave (
        input  i_valid, i_insn, i_gpr, i_flush, i_wb_valid, i_wb_dst, i_ready,
        output o_ready, o_valid, o_to_state, o_alu_op, o_sz, o_src1, o_src2,
               o_dst, o_illegal, o_halted
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decode_stage : registered decode stage with busy scoreboard, sticky halt  |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module decode_stage #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    decode_if.slave bus
);
    localparam int         IDXW                 = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [3:0] c_state_execute      = 4'd0;
    localparam logic [3:0] c_state_src1_to_dst  = 4'd1;
    localparam logic [3:0] c_state_halt         = 4'd2;

    logic [1:0]       w_k;
    logic [4:0]       w_dst, w_s1, w_s2;
    logic [3:0]       w_n;
    logic [15:0]      w_imm;
    logic [IDXW-1:0]  w_di, w_s1i, w_s2i, w_wbi;
    logic             w_dst_ok, w_s1_ok, w_s2_ok, w_n_ok, w_wb_ok;
    logic             w_is_halt, w_is_li, w_is_alu, w_writes, w_hazard;
    logic             w_ready, w_accept, w_illegal;
    logic [3:0]       w_to_state, w_alu_op;
    logic [XLEN-1:0]  w_src1, w_src2;
    logic [XLEN-1:0]  w_gpr [NREGS];
    logic             w_unused;

    logic             valid_q, valid_d;
    logic             halted_q;
    logic [NREGS-1:0] busy_q, busy_d;
    logic [3:0]       to_state_q, alu_op_q;
    logic [1:0]       sz_q;
    logic [XLEN-1:0]  src1_q, src2_q;
    logic [4:0]       dst_q;
    logic             illegal_q;

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_gpr
        assign w_gpr[gi] = bus.i_gpr[gi*XLEN +: XLEN];
    end

    assign w_k      = bus.i_insn[30:29];
    assign w_dst    = bus.i_insn[24:20];
    assign w_s1     = bus.i_insn[19:15];
    assign w_s2     = bus.i_insn[14:10];
    assign w_n      = bus.i_insn[19:16];
    assign w_imm    = bus.i_insn[15:0];
    assign w_unused = bus.i_insn[31];

    assign w_di     = w_dst[IDXW-1:0];
    assign w_s1i    = w_s1[IDXW-1:0];
    assign w_s2i    = w_s2[IDXW-1:0];
    assign w_wbi    = bus.i_wb_dst[IDXW-1:0];
    assign w_dst_ok = 32'(w_dst) < NREGS;
    assign w_s1_ok  = 32'(w_s1) < NREGS;
    assign w_s2_ok  = 32'(w_s2) < NREGS;
    assign w_wb_ok  = 32'(bus.i_wb_dst) < NREGS;
    assign w_n_ok   = 32'(w_n) < (XLEN / 16);

    always_comb begin
        w_is_halt  = (w_k == 2'b00) && (bus.i_insn[28:0] == 29'd0);
        w_is_li    = (w_k == 2'b01) && w_n_ok && w_dst_ok;
        w_is_alu   = (w_k == 2'b11) && w_dst_ok && w_s1_ok && w_s2_ok;
        w_writes   = w_is_li || w_is_alu;
        w_illegal  = !(w_is_halt || w_is_li || w_is_alu);
        // Illegal ops touch no registers, so they never wait on the scoreboard.
        w_hazard   = (w_writes && busy_q[w_di])
                  || (w_is_alu && (busy_q[w_s1i] || busy_q[w_s2i]));
        w_to_state = c_state_execute;
        w_alu_op   = (w_k == 2'b11) ? bus.i_insn[3:0] : 4'd0;
        w_src1     = '0;
        w_src2     = '0;
        if (w_is_halt) begin
            w_to_state = c_state_halt;
        end else if (w_is_li) begin
            w_to_state = c_state_src1_to_dst;
            if (w_n == 4'd0) begin
                w_src1 = XLEN'(w_imm);
            end else begin
                w_src1 = w_gpr[w_di] | (XLEN'(w_imm) << {w_n, 4'b0000});
            end
        end else if (w_is_alu) begin
            w_src1 = w_gpr[w_s1i];
            w_src2 = w_gpr[w_s2i];
        end
    end

    assign w_ready  = !halted_q && !w_hazard && (!valid_q || bus.i_ready) && !bus.i_flush;
    assign w_accept = bus.i_valid && w_ready;

    always_comb begin
        busy_d = busy_q;
        if (bus.i_wb_valid && w_wb_ok) begin
            busy_d[w_wbi] = 1'b0;
        end
        if (w_accept && w_writes) begin
            busy_d[w_di] = 1'b1;
        end
        if (bus.i_flush) begin
            valid_d = 1'b0;
        end else if (w_accept) begin
            valid_d = 1'b1;
        end else if (bus.i_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            busy_q     <= '0;
            to_state_q <= c_state_execute;
            alu_op_q   <= 4'd0;
            sz_q       <= 2'd0;
            src1_q     <= '0;
            src2_q     <= '0;
            dst_q      <= 5'd0;
            illegal_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            busy_q  <= busy_d;
            if (w_accept && w_is_halt) begin
                halted_q <= 1'b1;
            end
            if (w_accept) begin
                to_state_q <= w_to_state;
                alu_op_q   <= w_alu_op;
                sz_q       <= bus.i_insn[28:27];
                src1_q     <= w_src1;
                src2_q     <= w_src2;
                dst_q      <= w_dst;
                illegal_q  <= w_illegal;
            end
        end
    end

    assign bus.o_ready    = w_ready;
    assign bus.o_valid    = valid_q;
    assign bus.o_halted   = halted_q;
    assign bus.o_to_state = to_state_q;
    assign bus.o_alu_op   = alu_op_q;
    assign bus.o_sz       = sz_q;
    assign bus.o_src1     = src1_q;
    assign bus.o_src2     = src2_q;
    assign bus.o_dst      = dst_q;
    assign bus.o_illegal  = illegal_q;
endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_decode_stage : scoreboard bench for decode_stage                       |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_decode_stage;
    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam logic [3:0] ST_EXEC = 4'd0;
    localparam logic [3:0] ST_S2D  = 4'd1;
    localparam logic [3:0] ST_HALT = 4'd2;

    typedef struct packed {
        logic [3:0]      st;
        logic [3:0]      op;
        logic [1:0]      sz;
        logic [XLEN-1:0] s1;
        logic [XLEN-1:0] s2;
        logic [4:0]      dst;
        logic            ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_if #(.XLEN(XLEN), .NREGS(NREGS)) dif ();
    decode_if #(.XLEN(32),   .NREGS(NREGS)) dif32 ();

    decode_stage #(.XLEN(XLEN), .NREGS(NREGS)) dut   (.i_clk(clk), .i_rst_n(rst_n), .bus(dif));
    decode_stage #(.XLEN(32),   .NREGS(NREGS)) dut32 (.i_clk(clk), .i_rst_n(rst_n), .bus(dif32));

    logic [XLEN-1:0]       regs [NREGS];
    logic [NREGS*XLEN-1:0] gflat;
    always_comb begin
        gflat = '0;
        for (int r = 0; r < NREGS; r++) gflat[r*XLEN +: XLEN] = regs[r];
    end
    assign dif.i_gpr   = gflat;
    assign dif32.i_gpr = '0;

    exp_t q[$];
    bit   busy_m [NREGS];
    bit   halted_m;
    bit   mon_en;
    int   total;
    int   bad;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic logic [31:0] li(input int d, input int n, input logic [15:0] imm);
        logic [31:0] w;
        w = '0;
        w[30:29] = 2'b01;
        w[24:20] = 5'(d);
        w[19:16] = 4'(n);
        w[15:0]  = imm;
        return w;
    endfunction

    function automatic logic [31:0] alu(input int op, input int d, input int a, input int b);
        logic [31:0] w;
        w = '0;
        w[30:29] = 2'b11;
        w[24:20] = 5'(d);
        w[19:15] = 5'(a);
        w[14:10] = 5'(b);
        w[3:0]   = 4'(op);
        return w;
    endfunction

    // 0 halt, 1 load-immediate chunk, 2 alu, 3 illegal
    function automatic int kind(input logic [31:0] w);
        if (w[30:29] == 2'b00 && w[28:0] == 29'd0) return 0;
        if (w[30:29] == 2'b01 && int'(w[19:16]) < XLEN / 16) return 1;
        if (w[30:29] == 2'b11) return 2;
        return 3;
    endfunction

    function automatic bit hz(input logic [31:0] w);
        case (kind(w))
            1: return busy_m[w[24:20]];
            2: return busy_m[w[24:20]] || busy_m[w[19:15]] || busy_m[w[14:10]];
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        int   n;
        n     = int'(w[19:16]);
        e     = '0;
        e.st  = ST_EXEC;
        e.sz  = w[28:27];
        e.dst = w[24:20];
        case (kind(w))
            0: e.st = ST_HALT;
            1: begin
                e.st = ST_S2D;
                if (n == 0) e.s1 = XLEN'(w[15:0]);
                else        e.s1 = regs[w[24:20]] | (XLEN'(w[15:0]) << (16 * n));
            end
            2: begin
                e.op = w[3:0];
                e.s1 = regs[w[19:15]];
                e.s2 = regs[w[14:10]];
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Entered at posedge+1; returns at the next posedge+1 with the DUT's o_ready.
    task automatic cycle(input bit v, input logic [31:0] w, input bit rdy, input bit fl,
                         input bit wbv, input logic [4:0] wbd, output bit seen);
        bit   er;
        bit   acc;
        exp_t e;
        dif.i_valid    = v;
        dif.i_insn     = w;
        dif.i_ready    = rdy;
        dif.i_flush    = fl;
        dif.i_wb_valid = wbv;
        dif.i_wb_dst   = wbd;
        #2;
        er   = !halted_m && !hz(w) && (q.size() == 0 || rdy) && !fl;
        seen = dif.o_ready;
        chk("o_ready", {63'd0, dif.o_ready}, {63'd0, er});
        chk("o_halted", {63'd0, dif.o_halted}, {63'd0, halted_m});
        acc = v && er;
        e   = model(w);
        @(posedge clk);
        if (acc) q.push_back(e);
        if (wbv) busy_m[wbd] = 1'b0;
        if (acc && (kind(w) == 1 || kind(w) == 2)) busy_m[w[24:20]] = 1'b1;
        if (acc && kind(w) == 0) halted_m = 1'b1;
        #1;
    endtask

    task automatic drain();
        bit s;
        for (int r = 0; r < NREGS; r++)
            if (busy_m[r]) cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'(r), s);
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, s);
    endtask

    task automatic model_reset();
        q.delete();
        for (int r = 0; r < NREGS; r++) busy_m[r] = 1'b0;
        halted_m = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && rst_n) begin
            chk("o_valid", {63'd0, dif.o_valid}, {63'd0, q.size() > 0});
            if (q.size() > 0) begin
                e = q[0];
                if (dif.o_valid) begin
                    chk("o_to_state", {60'd0, dif.o_to_state}, {60'd0, e.st});
                    chk("o_alu_op", {60'd0, dif.o_alu_op}, {60'd0, e.op});
                    chk("o_sz", {62'd0, dif.o_sz}, {62'd0, e.sz});
                    chk("o_src1", dif.o_src1, e.s1);
                    chk("o_src2", dif.o_src2, e.s2);
                    chk("o_dst", {59'd0, dif.o_dst}, {59'd0, e.dst});
                    chk("o_illegal", {63'd0, dif.o_illegal}, {63'd0, e.ill});
                end
                if (dif.i_ready || dif.i_flush) void'(q.pop_front());
            end
        end
    end

    initial begin
        bit          s;
        bit          rdy, fl, wbv, v;
        logic [4:0]  wbd;
        logic [31:0] w;
        total = 0;
        bad   = 0;
        mon_en = 1'b0;
        for (int r = 0; r < NREGS; r++) regs[r] = '0;
        model_reset();
        dif.i_valid = 0; dif.i_insn = '0; dif.i_ready = 0; dif.i_flush = 0;
        dif.i_wb_valid = 0; dif.i_wb_dst = '0;
        dif32.i_valid = 0; dif32.i_insn = '0; dif32.i_ready = 1; dif32.i_flush = 0;
        dif32.i_wb_valid = 0; dif32.i_wb_dst = '0;

        #1;
        chk("reset o_valid", {63'd0, dif.o_valid}, 64'd0);
        chk("reset o_halted", {63'd0, dif.o_halted}, 64'd0);
        chk("reset o_to_state", {60'd0, dif.o_to_state}, {60'd0, ST_EXEC});
        chk("reset o_src1", dif.o_src1, 64'd0);
        chk("reset o_dst", {59'd0, dif.o_dst}, 64'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Load-immediate pair: second chunk waits for r1's writeback.
        cycle(1, li(1, 0, 16'h1234), 1, 0, 0, 5'd0, s);
        chk("t1 LI accepted", {63'd0, s}, 64'd1);
        cycle(1, li(1, 1, 16'hABCD), 1, 0, 0, 5'd0, s);
        chk("t1 LIU1 stall", {63'd0, s}, 64'd0);
        regs[1] = 64'h1234;
        cycle(1, li(1, 1, 16'hABCD), 1, 0, 1, 5'd1, s);
        chk("t1 stall on wb cycle", {63'd0, s}, 64'd0);
        cycle(1, li(1, 1, 16'hABCD), 1, 0, 0, 5'd0, s);
        chk("t1 LIU1 accepted", {63'd0, s}, 64'd1);
        chk("t1 src1", dif.o_src1, 64'h0000_0000_ABCD_1234);
        drain();

        // Output hold while execute back-pressures.
        regs[1] = 64'h1111_2222_3333_4444;
        regs[2] = 64'h5555_6666_7777_8888;
        cycle(1, alu(2, 3, 1, 2), 1, 0, 0, 5'd0, s);
        for (int i = 0; i < 3; i++) begin
            cycle(1, alu(1, 8, 9, 10), 0, 0, 0, 5'd0, s);
            chk("t2 held ready", {63'd0, s}, 64'd0);
            chk("t2 held src1", dif.o_src1, regs[1]);
        end
        cycle(1, alu(1, 8, 9, 10), 1, 0, 0, 5'd0, s);
        chk("t2 consume+accept", {63'd0, s}, 64'd1);
        drain();

        // RAW stall released the cycle after writeback.
        cycle(1, alu(0, 4, 5, 6), 1, 0, 0, 5'd0, s);
        cycle(1, alu(0, 7, 4, 5), 1, 0, 0, 5'd0, s);
        chk("t3 RAW stall", {63'd0, s}, 64'd0);
        cycle(1, alu(0, 7, 4, 5), 1, 0, 1, 5'd4, s);
        chk("t3 stall at wb N", {63'd0, s}, 64'd0);
        cycle(1, alu(0, 7, 4, 5), 1, 0, 0, 5'd0, s);
        chk("t3 accept at N+1", {63'd0, s}, 64'd1);
        drain();

        // Illegal forms set no busy bit; a 32-bit instance rejects chunk 2.
        dif32.i_valid = 1; dif32.i_insn = li(2, 2, 16'h5555);
        cycle(1, 32'h4012_3456, 1, 0, 0, 5'd0, s);
        chk("t5 k=10 illegal", {63'd0, dif.o_illegal}, 64'd1);
        chk("t5 x32 k1=2 illegal", {63'd0, dif32.o_illegal}, 64'd1);
        dif32.i_insn = li(2, 1, 16'h5555);
        cycle(1, li(5, 4, 16'h7777), 1, 0, 0, 5'd0, s);
        chk("t5 k1=4 illegal", {63'd0, dif.o_illegal}, 64'd1);
        chk("t5 x32 k1=1 legal", {63'd0, dif32.o_illegal}, 64'd0);
        chk("t5 x32 k1=1 state", {60'd0, dif32.o_to_state}, {60'd0, ST_S2D});
        dif32.i_valid = 0;
        cycle(1, alu(0, 6, 5, 5), 1, 0, 0, 5'd0, s);
        chk("t5 no busy from illegal", {63'd0, s}, 64'd1);
        drain();

        // Flush drops the held op but keeps its busy bit.
        cycle(1, alu(0, 9, 1, 2), 1, 0, 0, 5'd0, s);
        cycle(0, 32'd0, 0, 1, 0, 5'd0, s);
        chk("t6 flush o_valid", {63'd0, dif.o_valid}, 64'd0);
        cycle(1, alu(0, 11, 9, 1), 1, 0, 0, 5'd0, s);
        chk("t6 busy kept", {63'd0, s}, 64'd0);
        drain();

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) regs[$urandom_range(0, 7)] = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0, 1, 2, 3: w = alu($urandom_range(0, 15), $urandom_range(0, 7),
                                    $urandom_range(0, 7), $urandom_range(0, 7));
                4, 5, 6:    w = li($urandom_range(0, 7), $urandom_range(0, 4), 16'($urandom));
                7:          w = {3'b010, 29'($urandom)};
                8:          w = {3'b000, 29'($urandom) | 29'd1};
                default:    w = li($urandom_range(0, 7), 0, 16'($urandom));
            endcase
            w[28:27] = 2'($urandom);
            w[31]    = 1'($urandom);
            if (kind(w) == 0) w[0] = 1'b1;
            v   = $urandom_range(0, 3) != 0;
            rdy = $urandom_range(0, 2) != 0;
            fl  = $urandom_range(0, 29) == 0;
            if (fl) rdy = 1'b0;
            wbv = $urandom_range(0, 2) == 0;
            wbd = 5'($urandom_range(0, 7));
            cycle(v, w, rdy, fl, wbv, wbd, s);
        end
        drain();

        // Asynchronous reset in the middle of a stall.
        cycle(1, alu(0, 10, 11, 12), 1, 0, 0, 5'd0, s);
        dif.i_valid = 1; dif.i_insn = alu(0, 13, 10, 11); dif.i_ready = 0;
        #2;
        chk("t6 pre-reset stall", {63'd0, dif.o_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("t6 reset o_valid", {63'd0, dif.o_valid}, 64'd0);
        chk("t6 reset o_src1", dif.o_src1, 64'd0);
        chk("t6 reset o_dst", {59'd0, dif.o_dst}, 64'd0);
        chk("t6 reset o_to_state", {60'd0, dif.o_to_state}, {60'd0, ST_EXEC});
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle(1, alu(0, 13, 10, 11), 1, 0, 0, 5'd0, s);
        chk("t6 busy cleared by reset", {63'd0, s}, 64'd1);
        drain();

        // HALT is presented downstream, then the stage refuses work until reset.
        cycle(1, 32'h0000_0000, 0, 0, 0, 5'd0, s);
        chk("t4 HALT accepted", {63'd0, s}, 64'd1);
        chk("t4 o_to_state", {60'd0, dif.o_to_state}, {60'd0, ST_HALT});
        chk("t4 o_halted", {63'd0, dif.o_halted}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, alu(0, 14, 15, 16), 1, 0, 0, 5'd0, s);
            chk("t4 ignored after halt", {63'd0, s}, 64'd0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4 reset clears halt", {63'd0, dif.o_halted}, 64'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle(1, alu(0, 14, 15, 16), 1, 0, 0, 5'd0, s);
        chk("t4 accept after reset", {63'd0, s}, 64'd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
